// File: rtl/ofs_plat_avalon_mem_rdwr_responder.sv
// Avalon split read/write memory responder backed by a local dual-port line RAM.
// Reads stream with a fixed two-cycle latency; writes return one response per burst.
module ofs_plat_avalon_mem_rdwr_responder #(
  parameter int ADDR_WIDTH      = 16,
  parameter int MEM_ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       reset_n,

  input  logic [ADDR_WIDTH-1:0]      rd_address,
  input  logic                       rd_read,
  input  logic [BURST_CNT_WIDTH-1:0] rd_burstcount,
  input  logic [DATA_WIDTH/8-1:0]    rd_byteenable,
  output logic                       rd_waitrequest,
  output logic [DATA_WIDTH-1:0]      rd_readdata,
  output logic                       rd_readdatavalid,
  output logic [1:0]                 rd_response,

  input  logic [ADDR_WIDTH-1:0]      wr_address,
  input  logic                       wr_write,
  input  logic [BURST_CNT_WIDTH-1:0] wr_burstcount,
  input  logic [DATA_WIDTH-1:0]      wr_writedata,
  input  logic [DATA_WIDTH/8-1:0]    wr_byteenable,
  output logic                       wr_waitrequest,
  output logic                       wr_writeresponsevalid,
  output logic [1:0]                 wr_response
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;
  typedef enum logic {WR_IDLE, WR_BURST} wr_state_t;
  typedef logic [MEM_ADDR_WIDTH-1:0]  idx_t;
  typedef logic [BURST_CNT_WIDTH-1:0] cnt_t;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> MEM_ADDR_WIDTH) == '0;
  endfunction

  // Holds both waitrequests high for the first edge after reset_n rises.
  logic ready;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ready <= 1'b0;
    else
      ready <= 1'b1;
  end

  // Read request channel
  rd_state_t rd_state;
  idx_t      rd_idx;
  cnt_t      rd_cnt;
  logic      rd_err;
  logic      rd_accept;
  logic      rd_issue;

  assign rd_waitrequest = !ready || (rd_state != RD_IDLE);
  assign rd_accept      = rd_read && !rd_waitrequest;
  assign rd_issue       = (rd_state == RD_BURST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state <= RD_IDLE;
      rd_idx   <= '0;
      rd_cnt   <= '0;
      rd_err   <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (rd_accept) begin
            rd_state <= RD_BURST;
            rd_idx   <= rd_address[MEM_ADDR_WIDTH-1:0];
            rd_cnt   <= (rd_burstcount == '0) ? cnt_t'(1) : rd_burstcount;
            rd_err   <= !in_range(rd_address) || (rd_burstcount == '0);
          end
        end
        RD_BURST: begin
          rd_idx <= rd_idx + idx_t'(1);
          rd_cnt <= rd_cnt - cnt_t'(1);
          if (rd_cnt == cnt_t'(1))
            rd_state <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Write channel: address and count are only meaningful on the first beat
  wr_state_t wr_state;
  idx_t      wr_idx;
  cnt_t      wr_left;
  logic      wr_err;
  logic      wr_accept;
  logic      first_err;
  logic      wr_done;
  logic      done_err;
  logic      ram_we;
  idx_t      ram_widx;

  assign wr_waitrequest = !ready;
  assign wr_accept      = wr_write && ready;
  assign first_err      = !in_range(wr_address) || (wr_burstcount == '0);
  assign done_err       = (wr_state == WR_IDLE) ? first_err : wr_err;
  assign wr_done        = wr_accept &&
                          (((wr_state == WR_IDLE) && (wr_burstcount <= cnt_t'(1))) ||
                           ((wr_state == WR_BURST) && (wr_left == cnt_t'(1))));

  always_comb begin
    ram_we   = 1'b0;
    ram_widx = wr_idx;
    if (wr_accept) begin
      if (wr_state == WR_IDLE) begin
        ram_we   = !first_err;
        ram_widx = wr_address[MEM_ADDR_WIDTH-1:0];
      end else begin
        ram_we   = !wr_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state              <= WR_IDLE;
      wr_idx                <= '0;
      wr_left               <= '0;
      wr_err                <= 1'b0;
      wr_writeresponsevalid <= 1'b0;
      wr_response           <= 2'b00;
    end else begin
      wr_writeresponsevalid <= wr_done;
      wr_response           <= (wr_done && done_err) ? 2'b10 : 2'b00;
      case (wr_state)
        WR_IDLE: begin
          if (wr_accept) begin
            wr_idx  <= wr_address[MEM_ADDR_WIDTH-1:0] + idx_t'(1);
            wr_left <= wr_burstcount - cnt_t'(1);
            wr_err  <= first_err;
            if (wr_burstcount > cnt_t'(1))
              wr_state <= WR_BURST;
          end
        end
        WR_BURST: begin
          if (wr_accept) begin
            wr_idx  <= wr_idx + idx_t'(1);
            wr_left <= wr_left - cnt_t'(1);
            if (wr_left == cnt_t'(1))
              wr_state <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Writes commit one edge after acceptance, aligning them with the first read
  // access of a request accepted on the same edge (read-before-write).
  logic                    we_q;
  idx_t                    widx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [BYTES-1:0]        be_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      we_q <= 1'b0;
    else
      we_q <= ram_we;
  end

  always_ff @(posedge clk) begin
    widx_q  <= ram_widx;
    wdata_q <= wr_writedata;
    be_q    <= wr_byteenable;
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;

  always_ff @(posedge clk) begin
    if (rd_issue)
      ram_q <= mem[rd_idx];
    if (we_q) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_q[b])
          mem[widx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  // Read return pipeline: RAM register stage then output register
  logic s1_valid;
  logic s1_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid         <= 1'b0;
      s1_err           <= 1'b0;
      rd_readdatavalid <= 1'b0;
      rd_readdata      <= '0;
      rd_response      <= 2'b00;
    end else begin
      s1_valid         <= rd_issue;
      s1_err           <= rd_err;
      rd_readdatavalid <= s1_valid;
      rd_readdata      <= (s1_valid && !s1_err) ? ram_q : '0;
      rd_response      <= (s1_valid && s1_err) ? 2'b10 : 2'b00;
    end
  end

  // Reads always return full lines, so byte enables have no effect
  logic unused_rd_byteenable;
  assign unused_rd_byteenable = ^rd_byteenable;

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_responder.sv
// Randomized scoreboard bench for the Avalon rd/wr memory responder.
// A line-array model predicts read data and write responses, including exact return cycles.
module tb_ofs_plat_avalon_mem_rdwr_responder;

  localparam int AW    = 16;
  localparam int MAW   = 10;
  localparam int DW    = 512;
  localparam int BCW   = 7;
  localparam int BYTES = DW / 8;
  localparam int LINES = 1 << MAW;

  logic            clk;
  logic            reset_n;
  logic [AW-1:0]   rd_address;
  logic            rd_read;
  logic [BCW-1:0]  rd_burstcount;
  logic [BYTES-1:0] rd_byteenable;
  logic            rd_waitrequest;
  logic [DW-1:0]   rd_readdata;
  logic            rd_readdatavalid;
  logic [1:0]      rd_response;
  logic [AW-1:0]   wr_address;
  logic            wr_write;
  logic [BCW-1:0]  wr_burstcount;
  logic [DW-1:0]   wr_writedata;
  logic [BYTES-1:0] wr_byteenable;
  logic            wr_waitrequest;
  logic            wr_writeresponsevalid;
  logic [1:0]      wr_response;

  ofs_plat_avalon_mem_rdwr_responder #(
    .ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BCW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rd_address(rd_address),
    .rd_read(rd_read),
    .rd_burstcount(rd_burstcount),
    .rd_byteenable(rd_byteenable),
    .rd_waitrequest(rd_waitrequest),
    .rd_readdata(rd_readdata),
    .rd_readdatavalid(rd_readdatavalid),
    .rd_response(rd_response),
    .wr_address(wr_address),
    .wr_write(wr_write),
    .wr_burstcount(wr_burstcount),
    .wr_writedata(wr_writedata),
    .wr_byteenable(wr_byteenable),
    .wr_waitrequest(wr_waitrequest),
    .wr_writeresponsevalid(wr_writeresponsevalid),
    .wr_response(wr_response)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    int            cyc;
  } rd_exp_t;

  typedef struct {
    logic [1:0] resp;
    int         cyc;
  } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];

  logic [DW-1:0]    model [LINES];
  logic [DW-1:0]    wd  [64];
  logic [BYTES-1:0] wbe [64];

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit is_err(input logic [AW-1:0] addr, input logic [BCW-1:0] bc);
    return ((addr >> MAW) != '0) || (bc == '0);
  endfunction

  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic abort(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: bound expired at cycle %0d", name, cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // Monitor: every cycle, pops an expectation for each presented beat/response.
  initial begin
    rd_exp_t re;
    wr_exp_t we;
    forever begin
      @(negedge clk);
      if (rd_readdatavalid) begin
        if (rd_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL rd_unexpected_beat: got beat %0h at cycle %0d, expected none", rd_readdata, cyc);
        end else begin
          re = rd_q.pop_front();
          check_output("rd_data", rd_readdata, re.data);
          check_output("rd_resp", DW'(rd_response), DW'(re.resp));
          check_output("rd_cycle", DW'(cyc), DW'(re.cyc));
        end
      end else begin
        check_output("rd_idle_data_zero", rd_readdata, '0);
      end
      if (wr_writeresponsevalid) begin
        if (wr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL wr_unexpected_resp: got resp %0h at cycle %0d, expected none", wr_response, cyc);
        end else begin
          we = wr_q.pop_front();
          check_output("wr_resp", DW'(wr_response), DW'(we.resp));
          check_output("wr_resp_cycle", DW'(cyc), DW'(we.cyc));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    abort("global_watchdog");
  end

  // Issues one read request; expectations are taken from the model at the accept edge.
  task automatic read_burst(input logic [AW-1:0] addr, input logic [BCW-1:0] bc, output int t_acc);
    int            n;
    int            guard;
    bit            err;
    logic [MAW-1:0] idx;
    logic [DW-1:0] tmp [$];
    n   = (bc == '0) ? 1 : int'(bc);
    err = is_err(addr, bc);
    @(negedge clk);
    rd_read       = 1'b1;
    rd_address    = addr;
    rd_burstcount = bc;
    rd_byteenable = {$urandom, $urandom};
    guard = 0;
    while (rd_waitrequest) begin
      @(negedge clk);
      guard++;
      if (guard > 200) abort("rd_accept_timeout");
    end
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      idx = addr[MAW-1:0] + MAW'(k);
      tmp.push_back(err ? '0 : model[idx]);
    end
    #1;
    t_acc   = cyc;
    rd_read = 1'b0;
    for (int k = 0; k < n; k++)
      rd_q.push_back('{data: tmp[k], resp: err ? 2'b10 : 2'b00, cyc: t_acc + 2 + k});
  endtask

  // Writes beats wd/wbe[0..]; the model is updated just after each accept edge.
  task automatic write_burst(input logic [AW-1:0] addr, input logic [BCW-1:0] bc, input bit gaps);
    int             n;
    int             guard;
    int             t;
    bit             err;
    logic [MAW-1:0] idx;
    n   = (bc == '0) ? 1 : int'(bc);
    err = is_err(addr, bc);
    idx = addr[MAW-1:0];
    t   = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (gaps && k > 0 && $urandom_range(0, 3) == 0) begin
        wr_write = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      wr_write      = 1'b1;
      wr_address    = (k == 0) ? addr : AW'($urandom);
      wr_burstcount = (k == 0) ? bc : BCW'($urandom);
      wr_writedata  = wd[k];
      wr_byteenable = wbe[k];
      guard = 0;
      while (wr_waitrequest) begin
        @(negedge clk);
        guard++;
        if (guard > 200) abort("wr_accept_timeout");
      end
      @(posedge clk);
      #1;
      t        = cyc;
      wr_write = 1'b0;
      if (!err) begin
        for (int b = 0; b < BYTES; b++)
          if (wbe[k][b]) model[idx][b*8 +: 8] = wd[k][b*8 +: 8];
      end
      idx = idx + MAW'(1);
    end
    wr_q.push_back('{resp: err ? 2'b10 : 2'b00, cyc: t});
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (rd_q.size() != 0 || wr_q.size() != 0) begin
      @(negedge clk);
      guard++;
      if (guard > 400) abort("drain_timeout");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_rd_waitrequest"}, DW'(rd_waitrequest), DW'(1));
    check_output({tag, "_wr_waitrequest"}, DW'(wr_waitrequest), DW'(1));
    check_output({tag, "_rd_valid"}, DW'(rd_readdatavalid), '0);
    check_output({tag, "_wr_respvalid"}, DW'(wr_writeresponsevalid), '0);
    check_output({tag, "_rd_response"}, DW'(rd_response), '0);
    check_output({tag, "_wr_response"}, DW'(wr_response), '0);
    check_output({tag, "_rd_data"}, rd_readdata, '0);
  endtask

  task automatic apply_stimulus();
    int             ta;
    int             tb;
    logic [AW-1:0]  addr;
    logic [BCW-1:0] bc;

    // Fill all lines so every later read has a known expectation
    for (int blk = 0; blk < LINES / 64; blk++) begin
      for (int k = 0; k < 64; k++) begin
        wd[k]  = rand_line();
        wbe[k] = '1;
      end
      write_burst(AW'(blk * 64), BCW'(64), 1'b0);
    end
    wait_idle();

    for (int k = 0; k < 4; k++) begin
      wd[k]  = DW'(8'hA0 + k);
      wbe[k] = '1;
    end
    write_burst(16'h0010, 7'd4, 1'b0);
    wait_idle();
    read_burst(16'h0010, 7'd4, ta);
    wait_idle();

    wd[0] = '1;  wbe[0] = '1;
    write_burst(16'd5, 7'd1, 1'b0);
    wd[0] = '0;  wbe[0] = BYTES'(1);
    write_burst(16'd5, 7'd1, 1'b0);
    wait_idle();
    read_burst(16'd5, 7'd1, ta);
    wait_idle();

    for (int k = 0; k < 3; k++) begin
      wd[k]  = rand_line();
      wbe[k] = '1;
    end
    write_burst(AW'(LINES - 2), 7'd3, 1'b0);
    wait_idle();
    read_burst(AW'(LINES - 2), 7'd3, ta);
    wait_idle();

    read_burst(16'h8000, 7'd2, ta);
    wait_idle();
    wd[0] = rand_line();  wbe[0] = '1;
    write_burst(16'd3, 7'd0, 1'b0);
    wait_idle();
    read_burst(16'd3, 7'd1, ta);
    wait_idle();

    // Back-to-back reads: B accepted N+1 edges after A
    read_burst(16'h0010, 7'd4, ta);
    read_burst(16'h0200, 7'd3, tb);
    check_output("rd_b2b_accept_cycle", DW'(tb), DW'(ta + 5));
    wait_idle();

    for (int i = 0; i < 4; i++) begin
      wd[0]  = rand_line();
      wbe[0] = BYTES'({$urandom, $urandom});
      write_burst(AW'(40 + i), 7'd1, 1'b0);
    end
    wait_idle();

    // Same-edge read/write of line 7
    wd[0] = DW'(8'h11);  wbe[0] = '1;
    write_burst(16'd7, 7'd1, 1'b0);
    wait_idle();
    wd[0] = DW'(8'h55);
    fork
      read_burst(16'd7, 7'd1, ta);
      write_burst(16'd7, 7'd1, 1'b0);
    join
    wait_idle();
    read_burst(16'd7, 7'd1, ta);
    wait_idle();

    // Reset during the second beat of an 8-beat read
    read_burst(16'd100, 7'd8, ta);
    while (cyc < ta + 3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midburst_reset");
    rd_q.delete();
    wr_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_output("release_rd_waitrequest", DW'(rd_waitrequest), DW'(1));
    check_output("release_wr_waitrequest", DW'(wr_waitrequest), DW'(1));
    @(negedge clk);
    check_output("ready_rd_waitrequest", DW'(rd_waitrequest), '0);
    check_output("ready_wr_waitrequest", DW'(wr_waitrequest), '0);
    repeat (8) @(negedge clk);
    read_burst(16'd100, 7'd8, ta);
    wait_idle();

    // Randomized mix of read and write bursts
    for (int op = 0; op < 40; op++) begin
      addr = AW'($urandom_range(0, LINES - 1));
      if ($urandom_range(0, 7) == 0) addr = addr | AW'($urandom_range(1, 63) << MAW);
      bc = ($urandom_range(0, 9) == 0) ? '0 : BCW'($urandom_range(1, 64));
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < 64; k++) begin
          wd[k]  = rand_line();
          wbe[k] = ($urandom_range(0, 1) == 0) ? '1 : BYTES'({$urandom, $urandom});
        end
        write_burst(addr, bc, 1'b1);
      end else begin
        read_burst(addr, bc, ta);
      end
      wait_idle();
    end
  endtask

  initial begin
    reset_n       = 1'b1;
    rd_read       = 1'b0;
    rd_address    = '0;
    rd_burstcount = '0;
    rd_byteenable = '0;
    wr_write      = 1'b0;
    wr_address    = '0;
    wr_burstcount = '0;
    wr_writedata  = '0;
    wr_byteenable = '0;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_output("first_edge_rd_waitrequest", DW'(rd_waitrequest), DW'(1));
    @(negedge clk);
    check_output("after_edge_rd_waitrequest", DW'(rd_waitrequest), '0);

    $display("[TB] starting stimulus");
    apply_stimulus();
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
